hififo_rr_tag_tracker: RTL
==========================

# hififo_rr_tag_tracker

Tag allocator and completion tracker placed between the from-PC read-request multiplexer and the PCIe TX engine, with a completion-side tap on the PCIe RX engine. Each 128-byte upstream read request receives a tag from a circular pool before it is forwarded to TX. Completion qwords arriving from RX are counted per tag. Tags retire strictly in allocation order, so the from-PC FIFO can release reassembled 128-byte blocks in sequence.

## Interface
- NTAGS, 32: tag pool size; power of 2, range 4..64.
- TAG_W, 5: log2(NTAGS).
- QW_PER_RR, 16: qwords per read request (128 bytes); power of 2, at most 64.

- clock  in  1  PCIe user clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- rr_valid  in  1  read request from mux valid.
- rr_ready  out  1  request accepted this cycle when rr_valid is also high.
- rr_addr  in  64  request byte address.
- rrm_valid  out  1  request to TX valid (registered).
- rrm_ready  in  1  TX accepts the request.
- rrm_addr  out  64  registered copy of rr_addr.
- rrm_tag  out  8  allocated tag, zero-extended from TAG_W bits.
- rc_valid  in  1  one completion qword from RX.
- rc_tag  in  8  completion tag.
- rc_index  in  6  qword index of this completion within its request.
- retire_valid  out  1  one-cycle pulse: the oldest request has been fully received.
- retire_tag  out  TAG_W  tag being retired.
- outstanding  out  TAG_W+1  count of allocated, not-yet-retired tags.
- error  out  1  sticky; set by any completion protocol violation.

## Operation
- State:
  - busy[NTAGS] and done[NTAGS] bit vectors.
  - cnt[NTAGS] qword counters, each log2(QW_PER_RR)+1 bits.
  - alloc_ptr and ret_ptr, both TAG_W bits; they wrap modulo NTAGS.
- Accept:
  - rr_ready = (~rrm_valid | rrm_ready) & ~busy[alloc_ptr] & ~reset. This is combinational.
  - On rr_valid & rr_ready:
    - rrm_valid<=1, rrm_addr<=rr_addr, rrm_tag<=alloc_ptr.
    - busy[alloc_ptr]<=1, cnt[alloc_ptr]<=0, done[alloc_ptr]<=0.
    - alloc_ptr<=alloc_ptr+1.
  - If there is no accept, rrm_ready & rrm_valid clears rrm_valid.
  - Pool full (busy[alloc_ptr]=1): rr_ready=0 and no request is dropped.
- Completion, on rc_valid:
  - The qword is valid when rc_tag[7:TAG_W]==0, busy[t]=1 and done[t]=0, where t=rc_tag[TAG_W-1:0].
  - A valid qword increments cnt[t].
  - When the incremented value equals QW_PER_RR, done[t]<=1.
  - rc_index != cnt[t]: error<=1. The qword is still counted.
  - Invalid tag (high bits set, tag not busy, or tag already done): error<=1, and no state change.
- Retire:
  - Each cycle where busy[ret_ptr] & done[ret_ptr]:
    - retire_valid<=1, retire_tag<=ret_ptr.
    - busy[ret_ptr]<=0, done[ret_ptr]<=0, ret_ptr<=ret_ptr+1.
  - Otherwise retire_valid<=0. At most one retire per cycle.
  - A request that completes out of order waits until every older tag has retired.
- outstanding: +1 on accept, -1 on retire, unchanged when both happen in the same cycle. Range 0..NTAGS.
- Error checks run in this order:
  - index/tag checks use pre-update cnt/busy;
  - an accept and a completion for different tags in the same cycle are independent.
- Reset:
  - All outputs 0 (rrm_valid, rrm_addr, rrm_tag, retire_valid, retire_tag, outstanding, error).
  - busy/done/cnt cleared, pointers 0.
  - Reset mid-operation discards outstanding tags. Completions arriving after reset for those tags set error.

## Timing
- Accept to rrm_valid: 1 cycle.
- Back-to-back accepts (one per cycle) sustain while rrm_ready=1 and the pool has free tags.
- Final completion qword at cycle N: done set at N+1, retire_valid high at N+2 (provided the tag is oldest).
- A retire at cycle N frees its tag for acceptance at N+1. No same-cycle free-and-reuse.
- error asserts the cycle after the offending rc_valid and stays high until reset.
- rrm_* outputs hold stable while rrm_valid=1 and rrm_ready=0.

## Test plan
- **Single request:** rr_addr=0x1000 accepted.
  - Expect rrm_valid at +1 with rrm_tag=0.
  - Feed 16 completions, tag 0, index 0..15. Expect retire_valid with retire_tag=0 two cycles after index 15.
  - outstanding returns 1->0; error=0.
- **Out-of-order completion:** issue tags 0,1,2; complete tag 2, then 1, then 0.
  - Expect no retire until tag 0 completes.
  - Then retire pulses in three consecutive cycles: 0,1,2.
- **Pool full and wrap:** issue 32 requests with no completions.
  - Expect outstanding=32 and rr_ready=0 on the 33rd.
  - Complete tag 0. Expect the 33rd request accepted with rrm_tag=0 one cycle after retire.
- **Backpressure:** hold rrm_ready=0 with rr_valid=1.
  - Expect one accept, rr_ready=0, and rrm_addr/rrm_tag stable.
  - Release rrm_ready. Expect the next accept the same cycle.
- **Errors:**
  - completion for tag 5 while idle -> error=1 and outstanding unchanged;
  - rc_tag=0x20 -> error=1;
  - index 3 sent as the first qword of a fresh tag -> error=1, and that tag needs 15 more qwords to retire.
- **Reset mid-operation:** 4 tags outstanding, assert reset for one cycle.
  - Expect all outputs 0 and outstanding=0.
  - A next accept gets tag 0.
  - A stale completion for tag 3 sets error.

Source files
------------

// File: rtl/hififo_rr_tag_tracker.sv
// Read-request tag allocator with per-tag completion counting and in-order retirement.
// Sits between the from-PC read mux and PCIe TX, with a completion tap on PCIe RX.
module hififo_rr_tag_tracker #(
    parameter int unsigned NTAGS     = 32,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned QW_PER_RR = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rr_valid,
    output logic             rr_ready,
    input  logic [63:0]      rr_addr,
    output logic             rrm_valid,
    input  logic             rrm_ready,
    output logic [63:0]      rrm_addr,
    output logic [7:0]       rrm_tag,
    input  logic             rc_valid,
    input  logic [7:0]       rc_tag,
    input  logic [5:0]       rc_index,
    output logic             retire_valid,
    output logic [TAG_W-1:0] retire_tag,
    output logic [TAG_W:0]   outstanding,
    output logic             error
);

    localparam int unsigned CNT_W = $clog2(QW_PER_RR) + 1;

    logic [NTAGS-1:0] busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] cnt_q [NTAGS];
    logic [CNT_W-1:0] cnt_d [NTAGS];
    logic [TAG_W-1:0] alloc_ptr_q, alloc_ptr_d, ret_ptr_q, ret_ptr_d;
    logic             rrm_valid_q, rrm_valid_d;
    logic [63:0]      rrm_addr_q, rrm_addr_d;
    logic [TAG_W-1:0] rrm_tag_q, rrm_tag_d;
    logic             retire_valid_q, retire_valid_d;
    logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
    logic [TAG_W:0]   outstanding_q, outstanding_d;
    logic             error_q, error_d;

    logic             accept, retire, rc_ok;
    logic [TAG_W-1:0] rc_t;
    logic [CNT_W-1:0] cnt_inc;
    logic [6:0]       cnt_ext;

    assign rr_ready = (~rrm_valid_q | rrm_ready) & ~busy_q[alloc_ptr_q] & ~reset;
    assign accept   = rr_valid & rr_ready;
    assign retire   = busy_q[ret_ptr_q] & done_q[ret_ptr_q];

    // Tag checks use pre-update state; an in-range tag must be busy and still collecting.
    assign rc_t    = rc_tag[TAG_W-1:0];
    assign rc_ok   = ((rc_tag >> TAG_W) == 8'd0) & busy_q[rc_t] & ~done_q[rc_t];
    assign cnt_inc = cnt_q[rc_t] + CNT_W'(1);
    assign cnt_ext = 7'(cnt_q[rc_t]);

    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        cnt_d          = cnt_q;
        alloc_ptr_d    = alloc_ptr_q;
        ret_ptr_d      = ret_ptr_q;
        rrm_valid_d    = rrm_valid_q;
        rrm_addr_d     = rrm_addr_q;
        rrm_tag_d      = rrm_tag_q;
        retire_valid_d = retire;
        retire_tag_d   = retire_tag_q;
        outstanding_d  = outstanding_q;
        error_d        = error_q;

        if (accept) begin
            rrm_valid_d          = 1'b1;
            rrm_addr_d           = rr_addr;
            rrm_tag_d            = alloc_ptr_q;
            busy_d[alloc_ptr_q]  = 1'b1;
            done_d[alloc_ptr_q]  = 1'b0;
            cnt_d[alloc_ptr_q]   = '0;
            alloc_ptr_d          = alloc_ptr_q + TAG_W'(1);
        end else if (rrm_ready) begin
            rrm_valid_d = 1'b0;
        end

        // Accept, completion and retire always touch distinct tags, so order here is free.
        if (rc_valid) begin
            if (rc_ok) begin
                cnt_d[rc_t] = cnt_inc;
                if (cnt_inc == CNT_W'(QW_PER_RR)) done_d[rc_t] = 1'b1;
                if ({1'b0, rc_index} != cnt_ext) error_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end

        if (retire) begin
            retire_tag_d       = ret_ptr_q;
            busy_d[ret_ptr_q]  = 1'b0;
            done_d[ret_ptr_q]  = 1'b0;
            ret_ptr_d          = ret_ptr_q + TAG_W'(1);
        end

        case ({accept, retire})
            2'b10:   outstanding_d = outstanding_q + (TAG_W+1)'(1);
            2'b01:   outstanding_d = outstanding_q - (TAG_W+1)'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q         <= '0;
            done_q         <= '0;
            for (int i = 0; i < int'(NTAGS); i++) cnt_q[i] <= '0;
            alloc_ptr_q    <= '0;
            ret_ptr_q      <= '0;
            rrm_valid_q    <= 1'b0;
            rrm_addr_q     <= '0;
            rrm_tag_q      <= '0;
            retire_valid_q <= 1'b0;
            retire_tag_q   <= '0;
            outstanding_q  <= '0;
            error_q        <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            cnt_q          <= cnt_d;
            alloc_ptr_q    <= alloc_ptr_d;
            ret_ptr_q      <= ret_ptr_d;
            rrm_valid_q    <= rrm_valid_d;
            rrm_addr_q     <= rrm_addr_d;
            rrm_tag_q      <= rrm_tag_d;
            retire_valid_q <= retire_valid_d;
            retire_tag_q   <= retire_tag_d;
            outstanding_q  <= outstanding_d;
            error_q        <= error_d;
        end
    end

    assign rrm_valid    = rrm_valid_q;
    assign rrm_addr     = rrm_addr_q;
    assign rrm_tag      = 8'(rrm_tag_q);
    assign retire_valid = retire_valid_q;
    assign retire_tag   = retire_tag_q;
    assign outstanding  = outstanding_q;
    assign error        = error_q;

endmodule
